// File: rtl/sram_controller.sv
// sram_controller
//
// Sequences each 32-bit MEM-stage load/store onto a 16-bit asynchronous
// SRAM. An access takes two half-word bus cycles (low half first) and then
// WAIT_CYCLES settle cycles. After that comes a single DONE cycle in which
// ready is high and the pipeline advances.
//
// State table:
//   IDLE   | no access in flight; a request starts one and latches the operands
//   ACC_LO | bus cycle for the low half-word (SRAM_ADDR lsb = 0)
//   ACC_HI | bus cycle for the high half-word (SRAM_ADDR lsb = 1)
//   WAIT   | settle period; counter runs 0..WAIT_CYCLES-1
//   DONE   | access finished; ready high for one cycle; requests ignored
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   wr_en, rd_en          store / load request levels (store wins if both are high)
//   address               byte address; SRAM word 0 sits at BASE_ADDR
//   write_data            store data
//   read_data             registered load data; only loads update it
//   ready                 high when no access is pending (low freezes the pipeline)
//   SRAM_DQ               bidirectional half-word data bus
//   SRAM_ADDR             half-word address {word offset, half select}
//   SRAM_WE_N, SRAM_OE_N  active-low write / output enables
//   SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  permanently enabled (tied low)

module sram_controller #(
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_WE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ACC_LO = 3'd1,
      ACC_HI = 3'd2,
      WAIT   = 3'd3,
      DONE   = 3'd4
   } state_t;

   // Count value on which WAIT hands over to DONE. When WAIT_CYCLES is 0,
   // WAIT is never entered, so the wrapped value does not matter.
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

   state_t      state;
   state_t      state_nx;
   logic [3:0]  wait_cnt;
   logic        op_wr;
   logic [16:0] word_q;
   logic [31:0] wdata_q;

   logic        start;
   logic [31:0] offset;
   logic        half;
   logic        we_n;
   logic        oe_n;
   logic        dq_oe;
   logic [15:0] dq_out;
   logic        rdy;

   // Out-of-range addresses alias silently. The byte-lane bits and the bits
   // above the SRAM depth are dropped here.
   logic        unused_offset_bits;

   assign start              = wr_en | rd_en;
   assign offset             = address - 32'(BASE_ADDR);
   assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         op_wr     <= 1'b0;
         word_q    <= '0;
         wdata_q   <= '0;
         read_data <= '0;
      end else begin
         state <= state_nx;

         if (state == IDLE && start) begin
            op_wr   <= wr_en;
            word_q  <= offset[18:2];
            wdata_q <= write_data;
         end

         if (state == WAIT) begin
            wait_cnt <= wait_cnt + 4'd1;
         end else begin
            wait_cnt <= '0;
         end

         if (state == ACC_LO && !op_wr) begin
            read_data[15:0] <= SRAM_DQ;
         end
         if (state == ACC_HI && !op_wr) begin
            read_data[31:16] <= SRAM_DQ;
         end
      end
   end

   always_comb begin
      state_nx = state;
      half     = 1'b0;
      we_n     = 1'b1;
      oe_n     = 1'b1;
      dq_oe    = 1'b0;
      dq_out   = wdata_q[15:0];
      rdy      = 1'b0;

      case (state)
         IDLE: begin
            rdy = ~wr_en & ~rd_en;
            if (start) begin
               state_nx = ACC_LO;
            end
         end

         ACC_LO: begin
            we_n     = ~op_wr;
            oe_n     = op_wr;
            dq_oe    = op_wr;
            state_nx = ACC_HI;
         end

         ACC_HI: begin
            half     = 1'b1;
            dq_out   = wdata_q[31:16];
            we_n     = ~op_wr;
            oe_n     = op_wr;
            dq_oe    = op_wr;
            state_nx = (WAIT_CYCLES == 0) ? DONE : WAIT;
         end

         WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
               state_nx = DONE;
            end
         end

         DONE: begin
            rdy      = 1'b1;
            state_nx = IDLE;
         end

         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign ready     = rdy;
   assign SRAM_ADDR = {word_q, half};
   assign SRAM_WE_N = we_n;
   assign SRAM_OE_N = oe_n;
   assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller. Instance u_dut uses the default
// settle period of 3 cycles and is attached to a 64-word SRAM model.
// Instance u_dut0 has a settle period of 0 and an SRAM model that returns
// 0x1000 | addr[5:0] when read.

module tb_sram_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        probe_en;

   logic        wr_en, rd_en;
   logic [31:0] address, write_data;
   logic [31:0] read_data;
   logic        ready;
   wire  [15:0] sram_dq;
   logic [17:0] sram_addr;
   logic        we_n, oe_n, ce_n, ub_n, lb_n;

   logic        rd_en1;
   logic [31:0] address1;
   logic [31:0] read_data1;
   logic        ready1;
   wire  [15:0] sram_dq1;
   logic [17:0] sram_addr1;
   logic        we_n1, oe_n1, ce_n1, ub_n1, lb_n1;

   logic [15:0] mem [64];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(3)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .ready      (ready),
      .SRAM_DQ    (sram_dq),
      .SRAM_ADDR  (sram_addr),
      .SRAM_WE_N  (we_n),
      .SRAM_OE_N  (oe_n),
      .SRAM_CE_N  (ce_n),
      .SRAM_UB_N  (ub_n),
      .SRAM_LB_N  (lb_n)
   );

   sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(0)) u_dut0 (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (1'b0),
      .rd_en      (rd_en1),
      .address    (address1),
      .write_data (32'h0),
      .read_data  (read_data1),
      .ready      (ready1),
      .SRAM_DQ    (sram_dq1),
      .SRAM_ADDR  (sram_addr1),
      .SRAM_WE_N  (we_n1),
      .SRAM_OE_N  (oe_n1),
      .SRAM_CE_N  (ce_n1),
      .SRAM_UB_N  (ub_n1),
      .SRAM_LB_N  (lb_n1)
   );

   // SRAM models. The probe drives a known pattern onto an otherwise idle bus
   // so that a stray controller drive shows up as a corrupted value.
   assign sram_dq  = (!oe_n && we_n) ? mem[sram_addr[5:0]] :
                     (probe_en ? 16'h5A5A : 16'hzzzz);
   assign sram_dq1 = (!oe_n1 && we_n1) ? (16'h1000 | {10'h0, sram_addr1[5:0]}) : 16'hzzzz;

   always @(negedge clk) begin
      if (!we_n) mem[sram_addr[5:0]] <= sram_dq;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic exp_pat [8];
      logic we_seen;
      exp_pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      rst = 1'b1; probe_en = 1'b0;
      wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
      rd_en1 = 1'b0; address1 = '0;
      for (int i = 0; i < 64; i++) mem[i] = 16'h0000;

      // ---- reset and idle ----
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_ready",     {31'h0, ready},  32'h1);
      check("rst_we_n",      {31'h0, we_n},   32'h1);
      check("rst_oe_n",      {31'h0, oe_n},   32'h1);
      check("rst_read_data", read_data,       32'h0);
      check("rst_sram_addr", {14'h0, sram_addr}, 32'h0);
      check("rst_tied",      {29'h0, ce_n, ub_n, lb_n}, 32'h0);
      check("rst_ready1",    {31'h0, ready1}, 32'h1);
      probe_en = 1'b1;
      #1;
      check("rst_dq_free",   {16'h0, sram_dq}, 32'h5A5A);
      probe_en = 1'b0;

      // ---- store 0xDEADBEEF at 1032 ----
      next_cycle();
      wr_en = 1'b1; address = 32'd1032; write_data = 32'hDEADBEEF;
      #1;
      check("st_ready_c0", {31'h0, ready}, 32'h0);
      for (int k = 1; k <= 5; k++) begin
         next_cycle();
         #1;
         check("st_ready_low", {31'h0, ready}, 32'h0);
         if (k == 1) begin
            check("st_lo_addr", {14'h0, sram_addr}, 32'd4);
            check("st_lo_dq",   {16'h0, sram_dq},   32'hBEEF);
            check("st_lo_we_n", {31'h0, we_n},      32'h0);
            check("st_lo_oe_n", {31'h0, oe_n},      32'h1);
         end
         if (k == 2) begin
            check("st_hi_addr", {14'h0, sram_addr}, 32'd5);
            check("st_hi_dq",   {16'h0, sram_dq},   32'hDEAD);
            check("st_hi_we_n", {31'h0, we_n},      32'h0);
         end
         if (k == 3) check("st_wait_we_n", {31'h0, we_n}, 32'h1);
      end
      next_cycle();
      wr_en = 1'b0;
      #1;
      check("st_done_ready", {31'h0, ready},     32'h1);
      check("st_done_addr",  {14'h0, sram_addr}, 32'd4);
      next_cycle();
      #1;
      check("st_mem_lo", {16'h0, mem[4]}, 32'hBEEF);
      check("st_mem_hi", {16'h0, mem[5]}, 32'hDEAD);

      // ---- load from 1032 ----
      next_cycle();
      rd_en = 1'b1; address = 32'd1032;
      #1;
      check("ld_ready_c0", {31'h0, ready}, 32'h0);
      we_seen = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         next_cycle();
         #1;
         if (!we_n) we_seen = 1'b1;
         check("ld_ready_low", {31'h0, ready}, 32'h0);
         if (k == 1) begin
            check("ld_lo_oe_n", {31'h0, oe_n},      32'h0);
            check("ld_lo_addr", {14'h0, sram_addr}, 32'd4);
         end
      end
      next_cycle();
      rd_en = 1'b0;
      #1;
      check("ld_done_ready", {31'h0, ready},   32'h1);
      check("ld_read_data",  read_data,        32'hDEADBEEF);
      check("ld_we_quiet",   {31'h0, we_seen}, 32'h0);

      // ---- both enables at 1024: write wins ----
      next_cycle();
      wr_en = 1'b1; rd_en = 1'b1; address = 32'd1024; write_data = 32'h12345678;
      for (int k = 1; k <= 5; k++) begin
         next_cycle();
         #1;
         if (k == 1) begin
            check("both_lo_addr", {14'h0, sram_addr}, 32'd0);
            check("both_lo_we_n", {31'h0, we_n},      32'h0);
         end
         if (k == 2) begin
            check("both_hi_addr", {14'h0, sram_addr}, 32'd1);
            check("both_hi_we_n", {31'h0, we_n},      32'h0);
         end
      end
      next_cycle();
      wr_en = 1'b0; rd_en = 1'b0;
      #1;
      check("both_done_ready", {31'h0, ready}, 32'h1);
      check("both_read_data",  read_data,      32'hDEADBEEF);
      next_cycle();
      #1;
      check("both_mem_lo", {16'h0, mem[0]}, 32'h5678);
      check("both_mem_hi", {16'h0, mem[1]}, 32'h1234);

      // ---- reset in ACC_HI of a write ----
      next_cycle();
      wr_en = 1'b1; address = 32'd1032; write_data = 32'hCAFEF00D;
      next_cycle();
      next_cycle();
      #1;
      check("ab_hi_we_n", {31'h0, we_n}, 32'h0);
      rst = 1'b1; wr_en = 1'b0;
      #1;
      check("ab_we_n",      {31'h0, we_n},      32'h1);
      check("ab_oe_n",      {31'h0, oe_n},      32'h1);
      check("ab_ready",     {31'h0, ready},     32'h1);
      check("ab_read_data", read_data,          32'h0);
      check("ab_sram_addr", {14'h0, sram_addr}, 32'h0);
      probe_en = 1'b1;
      #1;
      check("ab_dq_free",   {16'h0, sram_dq},   32'h5A5A);
      probe_en = 1'b0;
      next_cycle();
      rst = 1'b0;

      // ---- zero settle, two loads held back to back ----
      next_cycle();
      rd_en1 = 1'b1; address1 = 32'd1088;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) next_cycle();
         #1;
         check("z_ready_pat", {31'h0, ready1}, {31'h0, exp_pat[i]});
         if (i == 3 || i == 7) check("z_read_data", read_data1, 32'h10211020);
      end
      rd_en1 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
